// File: rtl/fifo_unpack_drain.sv
// ---------------------------------------------------------------------------
// fifo_unpack_drain
//
// Read-side nibble unpacker with flush/drain handshake. Words of 32 bits,
// each tagged with a count of valid nibbles (1..8), are buffered in a small
// word FIFO. An output stage holds the word currently being unpacked and
// presents one nibble at a time to the consumer. A level flush request
// stops new writes, lets the consumer drain everything buffered, then
// pulses fifo_flush_done_o for one cycle.
//
// Build option:
//   FIFO_UNPACK_MSB_FIRST_EN  when defined, each word is emitted starting at
//                             nibble count-1 down to nibble 0; otherwise
//                             nibble 0 up to count-1.
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   fifo_wr_valid_i    write strobe for one word
//   fifo_wr_data_i     32-bit word, valid nibbles in the low positions
//   fifo_wr_cnt_i      valid nibble count (0 = no write, 9..15 clamp to 8)
//   fifo_rd_valid_i    consumer pops the current nibble
//   fifo_flush_i       level flush/drain request
//   fifo_rd_data_o     current nibble (0 when nothing is available)
//   fifo_data_avail_o  output stage holds a nibble
//   fifo_empty_o       word FIFO and output stage both empty
//   fifo_full_o        word FIFO holds DEPTH entries
//   fifo_flush_done_o  one-cycle pulse when a drain completes
// ---------------------------------------------------------------------------
module fifo_unpack_drain #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_wr_valid_i,
  input  logic [31:0] fifo_wr_data_i,
  input  logic [3:0]  fifo_wr_cnt_i,
  input  logic        fifo_rd_valid_i,
  input  logic        fifo_flush_i,
  output logic [3:0]  fifo_rd_data_o,
  output logic        fifo_data_avail_o,
  output logic        fifo_empty_o,
  output logic        fifo_full_o,
  output logic        fifo_flush_done_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_HOLD
  } state_t;

  state_t state_q, state_d;

  // Word storage: {count[3:0], data[31:0]} per entry. Not reset; the
  // pointers and count define which entries are meaningful.
  logic [35:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] stage_word_q, stage_word_d;
  logic [3:0]  stage_cnt_q, stage_cnt_d;
  logic [2:0]  stage_idx_q, stage_idx_d;
  logic        stage_valid_q, stage_valid_d;

  logic        fifo_full;
  logic        fifo_nonempty;
  logic        block_empty;
  logic [3:0]  wr_cnt_clamped;
  logic        wr_accept;
  logic        pop;
  logic        last_nib;
  logic        stage_free;
  logic        load;
  logic [35:0] head;

  // -------------------------------------------------------------------------
  // Datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_full      = (count_q == CW'(DEPTH));
    fifo_nonempty  = (count_q != '0);
    block_empty    = !fifo_nonempty && !stage_valid_q;
    wr_cnt_clamped = (fifo_wr_cnt_i > 4'd8) ? 4'd8 : fifo_wr_cnt_i;

    // Acceptance looks only at the registered full flag, so a write that
    // arrives while full is dropped even if a load frees a slot this cycle.
    wr_accept = fifo_wr_valid_i && (state_q == ST_RUN) && !fifo_full
                && (fifo_wr_cnt_i != 4'd0);

    pop = fifo_rd_valid_i && stage_valid_q;

`ifdef FIFO_UNPACK_MSB_FIRST_EN
    last_nib = (stage_idx_q == 3'd0);
`else
    last_nib = ({1'b0, stage_idx_q} == (stage_cnt_q - 4'd1));
`endif

    // The stage can take the head word either when idle or when its last
    // nibble leaves this cycle, which gives back-to-back words no bubble.
    stage_free = !stage_valid_q || (pop && last_nib);
    load       = stage_free && fifo_nonempty;
    head       = mem_q[rd_ptr_q];
  end

  always_comb begin
    stage_word_d  = stage_word_q;
    stage_cnt_d   = stage_cnt_q;
    stage_idx_d   = stage_idx_q;
    stage_valid_d = stage_valid_q;

    if (load) begin
      stage_word_d  = head[31:0];
      stage_cnt_d   = head[35:32];
      stage_valid_d = 1'b1;
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      stage_idx_d   = 3'(head[35:32] - 4'd1);
`else
      stage_idx_d   = 3'd0;
`endif
    end else if (pop && last_nib) begin
      stage_valid_d = 1'b0;
      stage_idx_d   = 3'd0;
    end else if (pop) begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
      stage_idx_d   = stage_idx_q - 3'd1;
`else
      stage_idx_d   = stage_idx_q + 3'd1;
`endif
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_accept, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Flush state machine
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (fifo_flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Completion is judged on registered state only; dropping the
        // flush request here does not cancel the drain.
        if (block_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = fifo_flush_i ? ST_HOLD : ST_RUN;
      end
      ST_HOLD: begin
        if (!fifo_flush_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      stage_word_q  <= '0;
      stage_cnt_q   <= '0;
      stage_idx_q   <= '0;
      stage_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      stage_word_q  <= stage_word_d;
      stage_cnt_q   <= stage_cnt_d;
      stage_idx_q   <= stage_idx_d;
      stage_valid_q <= stage_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= {wr_cnt_clamped, fifo_wr_data_i};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_rd_data_o    = stage_valid_q ? stage_word_q[{stage_idx_q, 2'b00} +: 4] : 4'd0;
    fifo_data_avail_o = stage_valid_q;
    fifo_empty_o      = block_empty;
    fifo_full_o       = fifo_full;
    fifo_flush_done_o = (state_q == ST_DONE);
  end

endmodule
